// File: rtl/bias_param_ram_loader.sv
// Streams bias beats into an internal RAM at incrementing addresses. Exposes the
// same two-stage registered read port (addr0/ce0/q0) as the ROM-backed bias sources.
module bias_param_ram_loader #(
   parameter int BIAS_PRECISION_0       = 16,
   parameter int BIAS_PARALLELISM_DIM_0 = 1,
   parameter int BIAS_PARALLELISM_DIM_1 = 1,
   parameter int DEPTH                  = 32,
   parameter int PAR                    = BIAS_PARALLELISM_DIM_0 * BIAS_PARALLELISM_DIM_1,
   parameter int AWIDTH                 = $clog2(DEPTH) + 1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            load_start,
   input  logic [BIAS_PRECISION_0-1:0]     data_in [PAR-1:0],
   input  logic                            data_in_valid,
   output logic                            data_in_ready,
   output logic                            load_done,
   output logic [AWIDTH-1:0]               beat_count,
   input  logic [AWIDTH-1:0]               addr0,
   input  logic                            ce0,
   output logic [PAR*BIAS_PRECISION_0-1:0] q0
);

   localparam int W   = PAR * BIAS_PRECISION_0;
   localparam int RAW = $clog2(DEPTH);
   localparam logic [AWIDTH-1:0] LAST = AWIDTH'(DEPTH - 1);

   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

   state_t            state, state_nxt;
   logic [AWIDTH-1:0] cnt_nxt;
   logic              wr_en;
   logic [W-1:0]      wdata;
   logic [W-1:0]      mem [2**RAW];
   logic [W-1:0]      stage0, stage1;

   // element 0 lands in the LSBs
   for (genvar j = 0; j < PAR; j++) begin : g_pack
      assign wdata[BIAS_PRECISION_0*j +: BIAS_PRECISION_0] = data_in[j];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         beat_count <= '0;
      end else begin
         state      <= state_nxt;
         beat_count <= cnt_nxt;
      end
   end

   // ready/done depend only on registered state; a restart drops the coincident beat
   always_comb begin
      state_nxt     = state;
      cnt_nxt       = beat_count;
      wr_en         = 1'b0;
      data_in_ready = (state == LOAD);
      load_done     = (state == DONE);
      if (load_start) begin
         state_nxt = LOAD;
         cnt_nxt   = '0;
      end else if (state == LOAD && data_in_valid) begin
         wr_en   = 1'b1;
         cnt_nxt = beat_count + AWIDTH'(1);
         if (beat_count == LAST) state_nxt = DONE;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[beat_count[RAW-1:0]] <= wdata;
   end

   // read-before-write falls out of both sides using nonblocking updates
   always_ff @(posedge clk) begin
      if (rst) begin
         stage0 <= '0;
         stage1 <= '0;
      end else if (ce0) begin
         stage0 <= mem[addr0[RAW-1:0]];
         stage1 <= stage0;
      end
   end

   assign q0 = stage1;

endmodule

// File: doc/bias_param_ram_loader.md
# bias_param_ram_loader

Writer-side counterpart of the ROM-backed bias parameter sources. Accepts a valid/ready stream of bias beats (BIAS_PARALLELISM_DIM_0 × BIAS_PARALLELISM_DIM_1 elements per beat), packs each beat into one word and writes it into an internal RAM at incrementing addresses. It exposes the same two-stage registered read port (addr0/ce0/q0) as the bias ROMs, so a source block can read runtime-loaded biases instead of `$readmemh` contents.

## Interface
- BIAS_PRECISION_0, 16, element width in bits
- BIAS_PARALLELISM_DIM_0, 1, elements per beat, dim 0
- BIAS_PARALLELISM_DIM_1, 1, elements per beat, dim 1
- DEPTH, 32, beats per complete load (RAM words)
- PAR, BIAS_PARALLELISM_DIM_0*BIAS_PARALLELISM_DIM_1, derived
- AWIDTH, $clog2(DEPTH)+1, address/count width, derived

- clk  input  1  clock; all logic rising-edge
- rst  input  1  reset, synchronous, active-high
- load_start  input  1  pulse: begin (or restart) a load
- data_in  input  PAR×BIAS_PRECISION_0 (unpacked array [PAR-1:0])  beat elements
- data_in_valid  input  1  beat valid
- data_in_ready  output  1  loader accepts beat
- load_done  output  1  all DEPTH words written
- beat_count  output  AWIDTH  beats accepted in current load
- addr0  input  AWIDTH  read address
- ce0  input  1  read pipeline enable
- q0  output  PAR×BIAS_PRECISION_0  packed read data

## Operation
- FSM: IDLE, LOAD, DONE. Reset -> IDLE.
- IDLE: data_in_ready=0; load_start -> LOAD, beat_count<=0.
- LOAD: data_in_ready=1. Transfer = data_in_valid && data_in_ready. On transfer: RAM[beat_count] <= packed beat, beat_count++. Transfer with beat_count==DEPTH-1 -> DONE, beat_count<=DEPTH.
- DONE: data_in_ready=0, load_done=1; holds until load_start.
- load_start in any state (including LOAD mid-load, DONE) -> LOAD, beat_count<=0, load_done<=0; a beat presented that cycle is NOT written (restart wins). Old RAM contents are retained until overwritten.
- Packing: element j occupies bits [BIAS_PRECISION_0*j + BIAS_PRECISION_0-1 : BIAS_PRECISION_0*j]; element 0 in LSBs.
- Read port: stage0 <= RAM[addr0] when ce0; stage1 <= stage0 when ce0; q0 = stage1. Reads are legal in any state; addr0 >= DEPTH returns undefined data.
- Same-cycle write and read of one address: read returns old contents (read-before-write).
- rst mid-load: FSM -> IDLE, beat_count=0, load_done=0; RAM contents not cleared.

## Timing
- Reset values: data_in_ready=0, load_done=0, beat_count=0, q0=0 (both read stages reset to 0).
- data_in_ready decoded from registered state only; no combinational path from data_in_valid.
- load_start at edge N: data_in_ready=1 from cycle N+1.
- Write visible to read sampled the cycle after the transfer edge.
- Read latency: 2 ce0-enabled edges from addr0 to q0; ce0=0 freezes both stages.
- load_done asserts the cycle after the last transfer edge; data_in_ready drops in that same cycle.
- Full load of DEPTH beats with valid held high: DEPTH cycles from first ready cycle.

## Test plan
- Reset: after rst, data_in_ready=0, load_done=0, beat_count=0, q0=0; valid beats ignored in IDLE.
- Full load, DEPTH=32, PAR=1, valid always high, data_in[0]=0x1000+i: load_done after exactly 32 transfers; reading addr 0..31 with ce0=1 returns 0x1000+addr two cycles later.
- Throttled valid (valid 1 of every 3 cycles) and PAR=2 (elements 0xAAAA,0x5555): beat_count increments only on transfers; q0 = 0x5555AAAA for every word.
- Restart mid-load: load_start with valid beat at beat_count=10 -> beat dropped, beat_count=0, reload with 0x2000+i; addrs 0..31 read 0x2000+addr.
- ce0 stall: ce0 low for 3 cycles mid-read -> q0 holds; resumes with correct 2-stage ordering. Same-cycle write/read of addr 5 returns pre-write value.
- rst asserted at beat_count=7 -> IDLE, counters 0, RAM words 0..6 still readable with loaded values.
